vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Raster timing generator that produces the pixel coordinates and sync signals consumed by `color_mapper`. It drives `DrawX`/`DrawY` for a 640x480 @ 60 Hz VGA/HDMI raster and generates active-low horizontal and vertical sync. It also emits frame and vertical-blank strobes and a free-running frame counter. Game logic uses these to update `grid`, `text` and `score` only while no visible pixels are being drawn.

## Interface
Parameters:
- `H_VISIBLE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_VISIBLE`, 480, visible lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BACK`, 33, vertical back porch (lines)

Derived values: `H_TOTAL` = sum of the H parameters (800); `V_TOTAL` = sum of the V parameters (525).

Ports:
- `Clk`  in  1  system clock; all state changes on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `pix_en`  in  1  pixel-clock enable; counters advance only on cycles where it is 1 (tie high at 25 MHz)
- `DrawX`  out  10  current horizontal count, 0..H_TOTAL-1
- `DrawY`  out  10  current vertical count, 0..V_TOTAL-1
- `hs`  out  1  horizontal sync, active low
- `vs`  out  1  vertical sync, active low
- `vde`  out  1  video data enable; 1 when DrawX < H_VISIBLE and DrawY < V_VISIBLE
- `frame_start`  out  1  single-cycle strobe when the raster wraps to (0,0)
- `vblank_start`  out  1  single-cycle strobe when the raster enters (0, V_VISIBLE)
- `frame_count`  out  8  number of completed frames, modulo 256

## Operation
- Two counters, `hc` and `vc`, drive `DrawX`/`DrawY` directly. No combinational path runs from any input to any output.
- On each `pix_en` cycle:
  - `hc` increments.
  - At `hc == H_TOTAL-1`, `hc` wraps to 0 and `vc` increments.
  - At `vc == V_TOTAL-1` together with the hc wrap, `vc` wraps to 0.
- `hs`, `vs`, `vde`, `frame_start` and `vblank_start` are registered.
  - Each is computed from the next-state counter values, so it describes the same pixel as the `DrawX`/`DrawY` presented in the same cycle.
- `hs` = 0 while `H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC`, i.e. 656..751.
- `vs` = 0 while `V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC`, i.e. 490..491, for the full width of those lines.
- `frame_start` = 1 for exactly one `Clk` cycle: the cycle on which the counters first show (0,0) after a wrap.
  - On that same edge, `frame_count` increments. It wraps from 255 to 0.
- `vblank_start` = 1 for exactly one `Clk` cycle: the cycle on which the counters first show (0,480).
- Both strobes are cleared on the next `Clk` edge even when `pix_en` = 0, so they never last longer than one cycle.
- When `pix_en` = 0:
  - Counters, `hs`, `vs`, `vde` and `frame_count` hold.
  - Strobes are cleared.
- Counter logic is 10 bits wide. Parameters must keep `H_TOTAL` and `V_TOTAL` at or below 1024; no saturation logic is provided.

## Timing
- Reset values, held while `reset_n` = 0:
  - `DrawX` = 0, `DrawY` = 0
  - `hs` = 1, `vs` = 1, `vde` = 0
  - `frame_start` = 0, `vblank_start` = 0
  - `frame_count` = 0
- Reset asserts immediately and asynchronously, mid-line or mid-frame. No strobe is emitted on entry to or exit from reset.
- The first `pix_en` edge after reset release moves the raster to (1,0) with `vde` = 1.
- The (0,0) pixel of the first frame after reset is presented with `vde` = 0. This is accepted behaviour.
- `frame_start` is not asserted for the initial (0,0) after reset; the first `frame_start` marks the end of frame 0.
- Latency: 0 cycles between a `DrawX`/`DrawY` value and its `hs`/`vs`/`vde`. Downstream logic adds its own pipeline delay to the sync signals if it registers RGB.
- With `pix_en` held at 1:
  - One line is 800 cycles and one frame is 420000 cycles.
  - `vblank_start` precedes the next `frame_start` by 45 × 800 = 36000 cycles.

## Test plan
- **Reset:** assert `reset_n` = 0 mid-frame at (300,200) → all outputs take their reset values within the same cycle. After release with `pix_en` = 1, the first edge gives `DrawX` = 1, `DrawY` = 0, `vde` = 1.
- **Horizontal sync:** `pix_en` = 1, observe line 0 → `hs` falls when `DrawX` = 656 and rises when `DrawX` = 752 (96 cycles low). `vde` goes to 0 at `DrawX` = 640.
- **Line wrap:** drive to `DrawX` = 799, `DrawY` = 5 → next cycle `DrawX` = 0, `DrawY` = 6, `vde` = 1, no strobe.
- **Vertical blank and frame wrap:**
  - At (799,479) → next cycle is (0,480) with `vblank_start` = 1 for one cycle and `vde` = 0.
  - `vs` = 0 for `DrawY` = 490..491 only.
  - At (799,524) → next cycle is (0,0) with `frame_start` = 1 and `frame_count` +1.
  - Run 256 frames → `frame_count` returns to its start value.
- **Enable gating:** toggle `pix_en` 1,0,0,1 around the frame wrap → counters freeze during the 0 cycles. `frame_start` is high for exactly one `Clk` cycle and does not repeat while `pix_en` is held at 0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster counters with registered syncs, video enable and frame/vblank strobes.
// Every registered output is derived from the next-state counters, so it matches the DrawX/DrawY shown alongside it.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       Clk,
    input  logic       reset_n,
    input  logic       pix_en,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       vde,
    output logic       frame_start,
    output logic       vblank_start,
    output logic [7:0] frame_count
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_BEG   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] r_hc, r_vc, w_hc_nxt, w_vc_nxt;
    logic [7:0] r_fc;
    logic       r_hs, r_vs, r_vde, r_fs, r_vb;
    logic       w_h_end, w_v_end, w_wrap, w_vb_hit;

    assign w_h_end  = r_hc == H_LAST;
    assign w_v_end  = r_vc == V_LAST;
    assign w_wrap   = w_h_end && w_v_end;
    assign w_hc_nxt = w_h_end ? 10'd0 : r_hc + 10'd1;
    assign w_vc_nxt = w_h_end ? (w_v_end ? 10'd0 : r_vc + 10'd1) : r_vc;
    assign w_vb_hit = w_h_end && w_vc_nxt == V_VIS;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hc  <= '0;
            r_vc  <= '0;
            r_hs  <= 1'b1;
            r_vs  <= 1'b1;
            r_vde <= 1'b0;
            r_fs  <= 1'b0;
            r_vb  <= 1'b0;
            r_fc  <= '0;
        end else begin
            // strobes are qualified by pix_en so a stalled raster never repeats them
            r_fs <= pix_en && w_wrap;
            r_vb <= pix_en && w_vb_hit;
            if (pix_en) begin
                r_hc  <= w_hc_nxt;
                r_vc  <= w_vc_nxt;
                r_hs  <= !(w_hc_nxt >= HS_BEG && w_hc_nxt < HS_END);
                r_vs  <= !(w_vc_nxt >= VS_BEG && w_vc_nxt < VS_END);
                r_vde <= w_hc_nxt < H_VIS && w_vc_nxt < V_VIS;
                if (w_wrap) r_fc <= r_fc + 8'd1;
            end
        end
    end

    assign DrawX        = r_hc;
    assign DrawY        = r_vc;
    assign hs           = r_hs;
    assign vs           = r_vs;
    assign vde          = r_vde;
    assign frame_start  = r_fs;
    assign vblank_start = r_vb;
    assign frame_count  = r_fc;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench; dut_a uses default 640x480 timing, dut_b a 16x12 raster for frame-level runs.
module tb_vga_timing_gen;
    logic       Clk = 1'b0;
    logic       rst_a = 1'b0, rst_b = 1'b0, pix_a = 1'b1, pix_b = 1'b1;
    logic [9:0] xa, ya, xb, yb;
    logic       hsa, vsa, vdea, fsa, vba, hsb, vsb, vdeb, fsb, vbb;
    logic [7:0] fca, fcb;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_bad = 0;

    typedef struct {
        int          cyc;
        bit          b;
        logic [32:0] v;
        string       tag;
    } exp_t;
    exp_t sb[$];

    vga_timing_gen dut_a (
        .Clk(Clk), .reset_n(rst_a), .pix_en(pix_a), .DrawX(xa), .DrawY(ya), .hs(hsa), .vs(vsa),
        .vde(vdea), .frame_start(fsa), .vblank_start(vba), .frame_count(fca)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
    ) dut_b (
        .Clk(Clk), .reset_n(rst_b), .pix_en(pix_b), .DrawX(xb), .DrawY(yb), .hs(hsb), .vs(vsb),
        .vde(vdeb), .frame_start(fsb), .vblank_start(vbb), .frame_count(fcb)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic ex(input int c, input bit b, input int x, input int y, input logic h, input logic v,
                      input logic de, input logic fs, input logic vb, input int fc, input string tag);
        exp_t e;
        e.cyc = c;
        e.b   = b;
        e.v   = {10'(x), 10'(y), h, v, de, fs, vb, 8'(fc)};
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge Clk);
            #1;
        end
    endtask

    always @(negedge Clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t        e;
            logic [32:0] a;
            e = sb.pop_front();
            a = e.b ? {xb, yb, hsb, vsb, vdeb, fsb, vbb, fcb} : {xa, ya, hsa, vsa, vdea, fsa, vba, fca};
            n_vec++;
            if (e.cyc != cyc || a !== e.v) begin
                n_bad++;
                $display("FAIL %s @cyc %0d (due %0d): got x=%0d y=%0d hs=%b vs=%b vde=%b fs=%b vb=%b fc=%0d, want x=%0d y=%0d hs=%b vs=%b vde=%b fs=%b vb=%b fc=%0d",
                         e.tag, cyc, e.cyc, a[32:23], a[22:13], a[12], a[11], a[10], a[9], a[8], a[7:0],
                         e.v[32:23], e.v[22:13], e.v[12], e.v[11], e.v[10], e.v[9], e.v[8], e.v[7:0]);
            end
        end
    end

    initial begin
        int c0, r0, b0;
        wait_cyc(2);
        ex(cyc, 0, 0, 0, 1, 1, 0, 0, 0, 0, "a_reset_held");
        ex(cyc, 1, 0, 0, 1, 1, 0, 0, 0, 0, "b_reset_held");
        wait_cyc(3);
        rst_a = 1'b1;
        c0 = cyc;
        ex(c0 + 1,    0, 1,   0, 1, 1, 1, 0, 0, 0, "a_first_edge");
        ex(c0 + 639,  0, 639, 0, 1, 1, 1, 0, 0, 0, "a_last_visible");
        ex(c0 + 640,  0, 640, 0, 1, 1, 0, 0, 0, 0, "a_vde_off");
        ex(c0 + 655,  0, 655, 0, 1, 1, 0, 0, 0, 0, "a_hs_before");
        ex(c0 + 656,  0, 656, 0, 0, 1, 0, 0, 0, 0, "a_hs_fall");
        ex(c0 + 751,  0, 751, 0, 0, 1, 0, 0, 0, 0, "a_hs_last_low");
        ex(c0 + 752,  0, 752, 0, 1, 1, 0, 0, 0, 0, "a_hs_rise");
        ex(c0 + 799,  0, 799, 0, 1, 1, 0, 0, 0, 0, "a_line0_end");
        ex(c0 + 800,  0, 0,   1, 1, 1, 1, 0, 0, 0, "a_line1_start");
        ex(c0 + 4799, 0, 799, 5, 1, 1, 0, 0, 0, 0, "a_line5_end");
        ex(c0 + 4800, 0, 0,   6, 1, 1, 1, 0, 0, 0, "a_line_wrap");
        ex(c0 + 5100, 0, 300, 6, 1, 1, 1, 0, 0, 0, "a_pre_reset");
        wait_cyc(c0 + 5101);
        rst_a = 1'b0;
        ex(c0 + 5101, 0, 0, 0, 1, 1, 0, 0, 0, 0, "a_async_reset");
        ex(c0 + 5103, 0, 0, 0, 1, 1, 0, 0, 0, 0, "a_reset_hold");
        wait_cyc(c0 + 5104);
        rst_a = 1'b1;
        r0 = cyc;
        ex(r0 + 1, 0, 1, 0, 1, 1, 1, 0, 0, 0, "a_release_first");
        ex(r0 + 2, 0, 2, 0, 1, 1, 1, 0, 0, 0, "a_release_second");
        wait_cyc(r0 + 3);
        rst_a = 1'b0;
        rst_b = 1'b1;
        b0 = cyc;
        ex(b0 + 1,     1, 1,  0,  1, 1, 1, 0, 0, 0,   "b_first_edge");
        ex(b0 + 95,    1, 15, 5,  1, 1, 0, 0, 0, 0,   "b_last_visible_line_end");
        ex(b0 + 96,    1, 0,  6,  1, 1, 0, 0, 1, 0,   "b_vblank_strobe");
        ex(b0 + 97,    1, 1,  6,  1, 1, 0, 0, 0, 0,   "b_vblank_clear");
        ex(b0 + 127,   1, 15, 7,  1, 1, 0, 0, 0, 0,   "b_vs_before");
        ex(b0 + 128,   1, 0,  8,  1, 0, 0, 0, 0, 0,   "b_vs_fall");
        ex(b0 + 138,   1, 10, 8,  0, 0, 0, 0, 0, 0,   "b_hs_and_vs_low");
        ex(b0 + 141,   1, 13, 8,  1, 0, 0, 0, 0, 0,   "b_hs_rise");
        ex(b0 + 159,   1, 15, 9,  1, 0, 0, 0, 0, 0,   "b_vs_last_line");
        ex(b0 + 160,   1, 0,  10, 1, 1, 0, 0, 0, 0,   "b_vs_rise");
        ex(b0 + 191,   1, 15, 11, 1, 1, 0, 0, 0, 0,   "b_frame_end");
        ex(b0 + 192,   1, 0,  0,  1, 1, 1, 1, 0, 1,   "b_frame_start");
        ex(b0 + 193,   1, 1,  0,  1, 1, 1, 0, 0, 1,   "b_frame_start_clear");
        ex(b0 + 384,   1, 0,  0,  1, 1, 1, 1, 0, 2,   "b_gate_wrap");
        ex(b0 + 385,   1, 0,  0,  1, 1, 1, 0, 0, 2,   "b_gate_hold1");
        ex(b0 + 386,   1, 0,  0,  1, 1, 1, 0, 0, 2,   "b_gate_hold2");
        ex(b0 + 387,   1, 1,  0,  1, 1, 1, 0, 0, 2,   "b_gate_resume");
        ex(b0 + 49153, 1, 15, 11, 1, 1, 0, 0, 0, 255, "b_fc_255");
        ex(b0 + 49154, 1, 0,  0,  1, 1, 1, 1, 0, 0,   "b_fc_wrap");
        wait_cyc(b0 + 384);
        pix_b = 1'b0;
        wait_cyc(b0 + 386);
        pix_b = 1'b1;
        wait_cyc(b0 + 49157);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL %s: never checked, due cyc %0d, now %0d", e.tag, e.cyc, cyc);
        end
        if (n_vec < 37) begin
            n_bad++;
            $display("FAIL vector count: only %0d applied", n_vec);
        end
        if (n_bad != 0) $display("FAIL: %0d miscompares", n_bad);
        else $display("PASS");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
